// File: rtl/dzcpu_ucode_sequencer.sv
// dzcpu microcode sequencer: opcode fetch, flow dispatch, uop address walk.
// Handles the 0xCB second-byte redirect into the CB flow table.
module dzcpu_ucode_sequencer #(
  parameter int         UOP_W     = 13,
  parameter logic [4:0] JCB_OP    = 5'h0F,
  parameter logic [7:0] RESET_IDX = 8'd0
) (
  input  logic             iClock,
  input  logic             iReset_n,
  input  logic [7:0]       iMop,
  input  logic             iMopValid,
  input  logic             iStall,
  input  logic             iZeroFlag,
  input  logic [7:0]       iMainIdx,
  input  logic [7:0]       iCbIdx,
  input  logic [UOP_W-1:0] iUop,
  output logic [7:0]       oMop,
  output logic             oMopReq,
  output logic [7:0]       oUopAddr,
  output logic             oUopValid,
  output logic             oPcInc,
  output logic             oFlagsUpdate,
  output logic             oCbMode
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_CBFETCH
  } state_t;

  localparam logic [3:0] F_INC        = 4'd1;
  localparam logic [3:0] F_EOF        = 4'd2;
  localparam logic [3:0] F_INC_EOF    = 4'd3;
  localparam logic [3:0] F_INC_EOF_Z  = 4'd4;
  localparam logic [3:0] F_INC_EOF_NZ = 4'd5;
  localparam logic [3:0] F_EOF_FU     = 4'd6;
  localparam logic [3:0] F_INC_EOF_FU = 4'd7;
  localparam logic [3:0] F_UPD_FLAGS  = 4'd8;

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] mop_q, mop_d;
  logic       req_q, req_d;
  logic       cb_q, cb_d;
  logic       cbpend_q, cbpend_d;

  logic [3:0] flow;
  logic [4:0] op;
  logic       is_inc;
  logic       is_fu;
  logic       is_eof;
  logic       run;
  logic       unused_operand;

  assign flow = iUop[UOP_W-1 -: 4];
  assign op   = iUop[8:4];
  assign unused_operand = ^iUop[3:0];

  always_comb begin
    is_inc = flow inside {F_INC, F_INC_EOF, F_INC_EOF_Z,
                          F_INC_EOF_NZ, F_INC_EOF_FU};
    is_fu  = flow inside {F_EOF_FU, F_INC_EOF_FU, F_UPD_FLAGS};
    is_eof = (flow inside {F_EOF, F_INC_EOF, F_EOF_FU, F_INC_EOF_FU})
           || (flow == F_INC_EOF_Z  &&  iZeroFlag)
           || (flow == F_INC_EOF_NZ && !iZeroFlag);
    run          = (state_q == S_EXEC) && !iStall;
    oUopValid    = run;
    oPcInc       = run && is_inc;
    oFlagsUpdate = run && is_fu;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    mop_d    = mop_q;
    req_d    = req_q;
    cb_d     = cb_q;
    cbpend_d = cbpend_q;
    if (!iStall) begin
      unique case (state_q)
        S_FETCH: begin
          if (iMopValid) begin
            mop_d   = iMop;
            cb_d    = 1'b0;
            req_d   = 1'b0;
            state_d = S_DECODE;
          end else begin
            req_d = 1'b1;
          end
        end
        S_DECODE: begin
          addr_d  = iMainIdx;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          if (is_eof) begin
            state_d = S_FETCH;
            cb_d    = 1'b0;
            req_d   = 1'b1;
          end else begin
            addr_d = addr_q + 8'd1;
            if (op == JCB_OP) begin
              state_d = S_CBFETCH;
              req_d   = 1'b1;
            end
          end
        end
        S_CBFETCH: begin
          // CB table index is valid one cycle after the byte lands in oMop
          if (cbpend_q) begin
            addr_d   = iCbIdx;
            cbpend_d = 1'b0;
            state_d  = S_EXEC;
          end else if (iMopValid) begin
            mop_d    = iMop;
            cb_d     = 1'b1;
            req_d    = 1'b0;
            cbpend_d = 1'b1;
          end else begin
            req_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q  <= S_FETCH;
      addr_q   <= RESET_IDX;
      mop_q    <= 8'd0;
      req_q    <= 1'b0;
      cb_q     <= 1'b0;
      cbpend_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      mop_q    <= mop_d;
      req_q    <= req_d;
      cb_q     <= cb_d;
      cbpend_q <= cbpend_d;
    end
  end

  assign oMop     = mop_q;
  assign oMopReq  = req_q;
  assign oUopAddr = addr_q;
  assign oCbMode  = cb_q;

endmodule
